fft_stage_controller: RTL

Sequencer for the radix-2 decimation-in-frequency FFT built around the combinational butterfly datapath. It walks LOG2N stages of N/2 butterflies each. For every butterfly it issues a paired read to the in-place sample RAM, a twiddle ROM address, and a delayed paired write-back of the butterfly outputs. It sits between the sample RAM/twiddle ROM and the top-level FFT wrapper, which pulses `start` and waits for `done`.

---
 rtl/fft_stage_controller.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fft_stage_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_stage_controller: radix-2 DIF FFT address/strobe sequencer.           |
// | Optional macro FFT_BITREV_EN adds a bit-reversed UNLOAD pass.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fft_stage_controller #(
   parameter int N     = 16,
   parameter int LOG2N = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [LOG2N-1:0] stage,
   output logic             rd_en,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   output logic [LOG2N-2:0] tw_addr,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b
`ifdef FFT_BITREV_EN
   ,
   output logic             out_en,
   output logic [LOG2N-1:0] out_index
`endif
);

   localparam int KW   = LOG2N - 1;
   localparam int HALF = N / 2;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RUN    = 3'd1;
   localparam logic [2:0] S_DRAIN  = 3'd2;
   localparam logic [2:0] S_DONE   = 3'd3;
`ifdef FFT_BITREV_EN
   localparam logic [2:0] S_UNLOAD = 3'd4;
`endif

   localparam logic [LOG2N-1:0] C_LAST_STAGE = LOG2N'(LOG2N - 1);
   localparam logic [KW-1:0]    C_K_LAST     = KW'(HALF - 1);

   logic [2:0]       state_q, state_d;
   logic [LOG2N-1:0] s_q, s_d;
   logic [KW-1:0]    k_q, k_d;
   logic             wr_en_q, wr_en_d;
   logic [LOG2N-1:0] wr_addr_a_q, wr_addr_a_d;
   logic [LOG2N-1:0] wr_addr_b_q, wr_addr_b_d;

   logic [LOG2N-1:0] sh, k_ext, span, pos, bfly_a, bfly_b;
   logic [KW-1:0]    bfly_tw;

`ifdef FFT_BITREV_EN
   localparam logic [LOG2N-1:0] C_J_LAST = LOG2N'(N - 1);
   logic [LOG2N-1:0] j_q, j_d;
   logic [LOG2N-1:0] j_rev;

   for (genvar i = 0; i < LOG2N; i++) begin : g_bitrev
      assign j_rev[i] = j_q[LOG2N-1-i];
   end
`endif

   // Butterfly k of stage s: groups of 2*span samples, pair offset span.
   always_comb begin
      sh      = C_LAST_STAGE - s_q;
      k_ext   = {1'b0, k_q};
      span    = LOG2N'(1) << sh;
      pos     = k_ext & (span - LOG2N'(1));
      bfly_a  = (((k_ext >> sh) << sh) << 1) | pos;
      bfly_b  = bfly_a + span;
      bfly_tw = KW'(pos << s_q);
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      k_d     = k_q;
`ifdef FFT_BITREV_EN
      j_d     = j_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               s_d     = '0;
               k_d     = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (k_q == C_K_LAST) state_d = S_DRAIN;
            else                 k_d     = k_q + 1'b1;
         end
         S_DRAIN: begin
            if (s_q != C_LAST_STAGE) begin
               s_d     = s_q + 1'b1;
               k_d     = '0;
               state_d = S_RUN;
            end else begin
`ifdef FFT_BITREV_EN
               j_d     = '0;
               state_d = S_UNLOAD;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef FFT_BITREV_EN
         S_UNLOAD: begin
            if (j_q == C_J_LAST) state_d = S_DONE;
            else                 j_d     = j_q + 1'b1;
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
      done      = (state_q == S_DONE);
      stage     = s_q;
      rd_en     = (state_q == S_RUN);
      rd_addr_a = (state_q == S_RUN) ? bfly_a  : '0;
      rd_addr_b = (state_q == S_RUN) ? bfly_b  : '0;
      tw_addr   = (state_q == S_RUN) ? bfly_tw : '0;
`ifdef FFT_BITREV_EN
      out_en    = 1'b0;
      out_index = '0;
      if (state_q == S_UNLOAD) begin
         busy      = 1'b1;
         rd_en     = 1'b1;
         rd_addr_a = j_rev;
         out_en    = 1'b1;
         out_index = j_q;
      end
`endif
   end

   // Unload reads never write back, so only butterfly reads arm the write.
   always_comb begin
      wr_en_d     = (state_q == S_RUN);
      wr_addr_a_d = rd_addr_a;
      wr_addr_b_d = rd_addr_b;
   end

   assign wr_en     = wr_en_q;
   assign wr_addr_a = wr_addr_a_q;
   assign wr_addr_b = wr_addr_b_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         s_q         <= '0;
         k_q         <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_a_q <= '0;
         wr_addr_b_q <= '0;
`ifdef FFT_BITREV_EN
         j_q         <= '0;
`endif
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         k_q         <= k_d;
         wr_en_q     <= wr_en_d;
         wr_addr_a_q <= wr_addr_a_d;
         wr_addr_b_q <= wr_addr_b_d;
`ifdef FFT_BITREV_EN
         j_q         <= j_d;
`endif
      end
   end

endmodule
`default_nettype wire
